// File: rtl/bitwise_logic_pipe.sv
// ---------------------------------------------------------------------------
// bitwise_logic_pipe
//
// Purpose:
//   Pipelined bitwise logic unit. Each accepted transaction selects one of
//   eight bitwise operations on two WIDTH-bit operands. The result travels
//   through STAGES elastic register stages with valid/ready handshakes on
//   both sides. The final stage also carries registered zero/all-ones flags.
//   A wrapping counter tracks completed output handshakes.
//
// Ports:
//   i_clk    in   1      clock; all state changes on the rising edge
//   i_rst    in   1      synchronous active-high reset
//   i_valid  in   1      input transaction valid
//   o_ready  out  1      unit accepts input this cycle (comb. from i_ready)
//   i_op     in   3      operation select, sampled with the operands
//   i_var1   in   WIDTH  operand A
//   i_var2   in   WIDTH  operand B (ignored by NOT A)
//   o_valid  out  1      output transaction valid (registered)
//   i_ready  in   1      consumer accepts output this cycle
//   o_res    out  WIDTH  result (registered)
//   o_zero   out  1      o_res == 0 (registered with the data)
//   o_ones   out  1      o_res == all ones (registered with the data)
//   o_cnt    out  CNT_W  output handshake count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module bitwise_logic_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_var1,
    input  logic [WIDTH-1:0] i_var2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zero,
    output logic             o_ones,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int LAST = STAGES - 1;

    // Bitwise operation selected by the 3-bit opcode.
    function automatic logic [WIDTH-1:0] bitwise_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a & ~b;
            3'b111:  r = ~a;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic [STAGES-1:0][WIDTH-1:0] data_r;
    logic [STAGES-1:0]            valid_r;
    logic                         zero_r;
    logic                         ones_r;
    logic [CNT_W-1:0]             cnt_r;

    logic [STAGES-1:0][WIDTH-1:0] in_data_s;
    logic [STAGES-1:0]            in_valid_s;
    logic [STAGES-1:0]            advance_s;
    logic                         out_hs_s;

    // Per-stage load source: stage 0 takes the fresh result, others the stage below.
    always_comb begin
        in_data_s     = {(STAGES*WIDTH){1'b0}};
        in_valid_s    = {STAGES{1'b0}};
        in_data_s[0]  = bitwise_op(i_op, i_var1, i_var2);
        in_valid_s[0] = i_valid;
        for (int k = 1; k < STAGES; k++) begin
            in_data_s[k]  = data_r[k-1];
            in_valid_s[k] = valid_r[k-1];
        end
    end

    // Advance chain in closed form: a stage may move when the consumer is
    // ready or some stage at or above it is empty. Written this way so no bit
    // of advance_s depends on another bit of itself.
    always_comb begin : adv_chain
        logic full_above;
        full_above = 1'b1;
        advance_s  = {STAGES{1'b0}};
        for (int k = LAST; k >= 0; k--) begin
            full_above   = full_above & valid_r[k];
            advance_s[k] = i_ready | ~full_above;
        end
    end

    assign out_hs_s = valid_r[LAST] & i_ready;

    // Stage registers; data only loads on a valid entry so a bubble keeps the last result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_r  <= {(STAGES*WIDTH){1'b0}};
            valid_r <= {STAGES{1'b0}};
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (advance_s[k]) begin
                    valid_r[k] <= in_valid_s[k];
                    if (in_valid_s[k]) begin
                        data_r[k] <= in_data_s[k];
                    end
                end
            end
        end
    end

    // Result flags, loaded together with the final-stage data so they always match o_res.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zero_r <= 1'b1;
            ones_r <= 1'b0;
        end else if (advance_s[LAST] && in_valid_s[LAST]) begin
            zero_r <= (in_data_s[LAST] == {WIDTH{1'b0}});
            ones_r <= (in_data_s[LAST] == {WIDTH{1'b1}});
        end
    end

    // Completed output handshake counter, free-running wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    assign o_ready = advance_s[0];
    assign o_valid = valid_r[LAST];
    assign o_res   = data_r[LAST];
    assign o_zero  = zero_r;
    assign o_ones  = ones_r;
    assign o_cnt   = cnt_r;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// ---------------------------------------------------------------------------
// tb_bitwise_logic_pipe
//
// Purpose:
//   Directed self-checking bench for bitwise_logic_pipe. Two instances share
//   the same stimulus: the default configuration (WIDTH=4, STAGES=2,
//   CNT_W=8) and a CNT_W=4 copy used for the counter wrap check.
//   Timing: inputs change 1 ns after a rising edge; outputs are sampled at
//   that same point, i.e. they show the state left by the previous edge.
//   "Step s" below means the window after edge s of a test.
// ---------------------------------------------------------------------------
module tb_bitwise_logic_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;

    logic       rdy;
    logic       ovalid;
    logic [3:0] res;
    logic       zero;
    logic       ones;
    logic [7:0] cnt;

    logic       rdy_w;
    logic       ovalid_w;
    logic [3:0] res_w;
    logic       zero_w;
    logic       ones_w;
    logic [3:0] cnt_w;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] got[$];

    // 10 ns clock.
    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy),
        .i_op(op), .i_var1(a), .i_var2(b),
        .o_valid(ovalid), .i_ready(ready), .o_res(res),
        .o_zero(zero), .o_ones(ones), .o_cnt(cnt)
    );

    bitwise_logic_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(4)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_w),
        .i_op(op), .i_var1(a), .i_var2(b),
        .o_valid(ovalid_w), .i_ready(ready), .o_res(res_w),
        .o_zero(zero_w), .o_ones(ones_w), .o_cnt(cnt_w)
    );

    // Record every output handshake that the coming rising edge will complete.
    always @(negedge clk) begin
        if (!rst && ovalid && ready) got.push_back(res);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b1;
        ready = 1'b1;
        op    = 3'b011;
        a     = 4'h5;
        b     = 4'h6;
        tick();
        tick();
        n_tests++;
        if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ovalid); end
        n_tests++;
        if (res !== 4'h0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res); end
        n_tests++;
        if (zero !== 1'b1 || ones !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got zero=%b ones=%b want zero=1 ones=0", zero, ones);
        end
        n_tests++;
        if (cnt !== 8'd0 || cnt_w !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt, cnt_w);
        end
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        n_tests++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy); end
        tick();
        n_tests++;
        if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_no_emit: got valid=%b want 0", ovalid); end
        got.delete();
    endtask

    task automatic test_op_sweep();
        logic [3:0] exp_res [8];
        exp_res = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'h2, 4'h5};
        do_reset();
        ready = 1'b1;
        for (int s = 0; s < 11; s++) begin
            n_tests++;
            if (s >= 2 && s < 10) begin
                if (ovalid !== 1'b1 || res !== exp_res[s-2] || zero !== 1'b0 || ones !== 1'b0) begin
                    n_fail++;
                    $display("FAIL op_sweep op=%0d: got valid=%b res=%h zero=%b ones=%b want valid=1 res=%h zero=0 ones=0",
                             s - 2, ovalid, res, zero, ones, exp_res[s-2]);
                end
            end else begin
                if (ovalid !== 1'b0) begin
                    n_fail++; $display("FAIL op_sweep_idle step=%0d: got valid=%b want 0", s, ovalid);
                end
            end
            if (s < 8) begin
                valid = 1'b1;
                op    = s[2:0];
                a     = 4'hA;
                b     = 4'hC;
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (cnt !== 8'd8) begin n_fail++; $display("FAIL op_sweep_cnt: got %0d want 8", cnt); end
    endtask

    task automatic test_nand_exhaustive();
        logic [7:0] idx;
        logic [3:0] ea, eb, er;
        logic       ez, eo;
        int         errs;
        errs = 0;
        do_reset();
        ready = 1'b1;
        for (int s = 0; s < 259; s++) begin
            if (s >= 2 && s < 258) begin
                idx = 8'(s - 2);
                ea  = idx[7:4];
                eb  = idx[3:0];
                er  = ~(ea & eb);
                eo  = ((ea & eb) == 4'h0);
                ez  = (ea == 4'hF) && (eb == 4'hF);
                n_tests++;
                if (ovalid !== 1'b1 || res !== er || zero !== ez || ones !== eo) begin
                    n_fail++;
                    errs++;
                    $display("FAIL nand A=%h B=%h: got valid=%b res=%h zero=%b ones=%b want valid=1 res=%h zero=%b ones=%b",
                             ea, eb, ovalid, res, zero, ones, er, ez, eo);
                end
            end
            if (s < 256) begin
                idx   = 8'(s);
                valid = 1'b1;
                op    = 3'b011;
                a     = idx[7:4];
                b     = idx[3:0];
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (errs != 0 || cnt !== 8'd0) begin
            n_fail++; $display("FAIL nand_total: errors=%0d cnt=%0d want errors=0 cnt=0 (256 wraps)", errs, cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ta [6];
        logic [3:0] tb [6];
        logic [3:0] te [6];
        logic       prev_stall;
        logic [3:0] prev_res;
        logic       prev_zero, prev_ones;
        logic       exp_rdy;
        int         k;
        ta = '{4'h3, 4'hF, 4'h6, 4'h9, 4'hA, 4'h0};
        tb = '{4'h1, 4'hF, 4'h5, 4'hC, 4'hA, 4'h7};
        te = '{4'hE, 4'h0, 4'hB, 4'h7, 4'h5, 4'hF};
        k = 0;
        prev_stall = 1'b0;
        prev_res   = 4'h0;
        prev_zero  = 1'b0;
        prev_ones  = 1'b0;
        do_reset();
        for (int s = 0; s < 16; s++) begin
            if (prev_stall) begin
                n_tests++;
                if (ovalid !== 1'b1 || res !== prev_res || zero !== prev_zero || ones !== prev_ones) begin
                    n_fail++;
                    $display("FAIL stall_hold step=%0d: got valid=%b res=%h zero=%b ones=%b want valid=1 res=%h zero=%b ones=%b",
                             s, ovalid, res, zero, ones, prev_res, prev_zero, prev_ones);
                end
            end
            ready = (s >= 3 && s <= 7) ? 1'b0 : 1'b1;
            #1;
            exp_rdy = (s >= 3 && s <= 7) ? 1'b0 : 1'b1;
            n_tests++;
            if (rdy !== exp_rdy) begin
                n_fail++; $display("FAIL bp_ready step=%0d: got %b want %b", s, rdy, exp_rdy);
            end
            prev_stall = ovalid && !ready;
            prev_res   = res;
            prev_zero  = zero;
            prev_ones  = ones;
            if (k < 6) begin
                valid = 1'b1;
                op    = 3'b011;
                a     = ta[k];
                b     = tb[k];
                if (rdy) k++;
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d results want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (got[i] !== te[i]) begin
                    n_fail++; $display("FAIL bp_order idx=%0d: got %h want %h", i, got[i], te[i]);
                end
            end
        end
        n_tests++;
        if (cnt !== 8'd6) begin n_fail++; $display("FAIL bp_cnt: got %0d want 6", cnt); end
    endtask

    task automatic test_reset_mid();
        got.delete();
        ready = 1'b0;
        n_tests++;
        if (cnt !== 8'd6) begin n_fail++; $display("FAIL mid_cnt_before: got %0d want 6", cnt); end
        valid = 1'b1;
        op    = 3'b011;
        a     = 4'h1;
        b     = 4'h1;
        tick();
        a = 4'h2;
        b = 4'h2;
        tick();
        valid = 1'b0;
        n_tests++;
        if (ovalid !== 1'b1 || rdy !== 1'b0) begin
            n_fail++; $display("FAIL mid_full: got valid=%b ready=%b want valid=1 ready=0", ovalid, rdy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (ovalid !== 1'b0 || cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_after_rst: got valid=%b cnt=%0d want valid=0 cnt=0", ovalid, cnt);
        end
        ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            n_tests++;
            if (ovalid !== 1'b0) begin
                n_fail++; $display("FAIL mid_ghost step=%0d: got valid=%b res=%h want valid=0", s, ovalid, res);
            end
        end
        n_tests++;
        if (got.size() != 0) begin
            n_fail++; $display("FAIL mid_discard: got %0d results want 0", got.size());
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        ready = 1'b1;
        for (int s = 0; s < 20; s++) begin
            if (s == 17) begin
                n_tests++;
                if (cnt_w !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", cnt_w); end
            end
            if (s == 18) begin
                n_tests++;
                if (cnt_w !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d want 0", cnt_w); end
            end
            if (s == 19) begin
                n_tests++;
                if (cnt_w !== 4'd1 || cnt !== 8'd17) begin
                    n_fail++; $display("FAIL wrap_17: got %0d/%0d want 1/17", cnt_w, cnt);
                end
            end
            if (s < 17) begin
                valid = 1'b1;
                op    = 3'b000;
                a     = 4'hF;
                b     = 4'hF;
            end else begin
                valid = 1'b0;
            end
            tick();
        end
    endtask

    // Test sequence.
    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        ready = 1'b0;
        op    = 3'b000;
        a     = 4'h0;
        b     = 4'h0;
        test_reset();
        test_op_sweep();
        test_nand_exhaustive();
        test_backpressure();
        test_reset_mid();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_pipe.md
Name: bitwise_logic_pipe

Overview:
Parametrised, pipelined bitwise logic unit that generalises the combinational bitwise NAND block.
- Selects one of eight bitwise operations per transaction on two WIDTH-bit operands.
- Registers the result through STAGES elastic pipeline stages with valid/ready handshakes on both sides.
- Adds zero/all-ones flags and a completed-transaction counter.
- Sits between an operand producer and a result consumer in the lab datapath; full throughput is one transaction per clock.

Parameters:
WIDTH, 4, operand/result width in bits (1..32)
STAGES, 2, pipeline register stages between input and output (1..4)
CNT_W, 8, width of the completed-transaction counter

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  input transaction valid
o_ready  output  1  unit can accept input this cycle
i_op  input  3  operation select, sampled with operands
i_var1  input  WIDTH  operand A
i_var2  input  WIDTH  operand B
o_valid  output  1  output transaction valid
i_ready  input  1  consumer accepts output this cycle
o_res  output  WIDTH  result
o_zero  output  1  o_res == 0
o_ones  output  1  o_res == all ones
o_cnt  output  CNT_W  count of output handshakes (o_valid & i_ready)

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- Reset, sampled on a rising edge: all stage valid bits 0, o_valid=0, o_res=0, o_zero=1, o_ones=0, o_cnt=0. o_ready=1 from the first cycle after reset. Reset mid-stream discards all in-flight transactions; none are emitted afterwards.
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 ANDN (A & ~B)
  - 111 NOT A (i_var2 ignored)
- Result is computed combinationally from i_op/i_var1/i_var2 and captured into stage 1 on input handshake (i_valid & o_ready).
- Stage k (1..STAGES) holds data+valid. Stage STAGES drives o_res/o_valid.
- Flags o_zero/o_ones are registered alongside the data in the final stage; they always match o_res.
- Advance rule:
  - Final stage: advance = !valid_last | i_ready.
  - Stage k: advance_k = !valid_k | advance_(k+1).
  - Stage k loads from stage k-1 (or from the input for k=1) when advance_k.
  - Stage k clears its valid when advance_k and the upstream stage is not valid.
- o_ready = advance_1 (combinational from i_ready through the chain; no skid buffer).
- Latency: input handshake in cycle N -> o_valid with that result in cycle N+STAGES when no stall.
- Throughput: one transaction per cycle with i_ready held 1. No bubbles are inserted and no transaction is lost or duplicated.
- Stall: while o_valid=1 and i_ready=0, o_res, o_zero, o_ones and o_valid are held stable. Upstream stages keep filling until all are valid, then o_ready=0.
- Capacity: at most STAGES transactions in flight.
- Input side: when o_ready=0, inputs are ignored. i_valid may be asserted or deasserted freely; there is no requirement to hold data.
- o_cnt increments by 1 on each output handshake and wraps modulo 2^CNT_W (e.g. 255 -> 0 at CNT_W=8).
- Simultaneous input and output handshake while full is legal: the pipeline shifts and occupancy is unchanged.
- o_valid, o_res and the flags never depend combinationally on inputs. o_ready depends combinationally on i_ready only.

Test Plan:
- Reset: assert i_rst 2 cycles with i_valid=1 -> o_valid=0, o_res=0, o_zero=1, o_cnt=0; o_ready=1 after release.
- Op sweep, WIDTH=4, STAGES=2, A=4'hA, B=4'hC, ops 0..7 back-to-back, i_ready=1 -> o_res sequence 8,E,6,7,1,9,2,5. Each result appears 2 cycles after its input handshake. o_cnt=8 at the end.
- Exhaustive NAND: all 256 (A,B) pairs, op=011, i_ready=1 -> every o_res == ~(A&B). o_ones=1 exactly when A&B==0; o_zero=1 exactly for A=B=4'hF. Zero mismatches.
- Backpressure: stream 6 NAND transactions, hold i_ready=0 for cycles 3..7 -> o_res/o_valid stable while stalled. o_ready=0 once 2 transactions are held. All 6 results emerge in order with no loss or duplication; o_cnt=6.
- Reset mid-operation: 2 transactions in flight, i_ready=0, then pulse i_rst -> o_valid=0 next cycle, o_cnt=0, and neither discarded result ever appears.
- Counter wrap, CNT_W=4: 17 output handshakes -> o_cnt reads 15 after the 15th and 1 after the 17th.
